// File: rtl/noise_gate_pkg.sv
// Shared types and helpers for the noise gate calibrator: FSM state encoding
// and a saturating left shift used to build the gate thresholds.
package noise_gate_pkg;

    typedef enum logic {
        ST_CAL = 1'b0,
        ST_RUN = 1'b1
    } ng_state_e;

    // Shift val (a width-bit unsigned value) left by sh; all ones of width bits on overflow.
    function automatic logic [63:0] sat_shl(input logic [63:0] val,
                                            input int unsigned sh,
                                            input int unsigned width);
        logic [63:0] mask;
        logic [63:0] v;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        v = val & mask;
        if (sh == 0) begin
            return v;
        end
        if (sh >= width) begin
            return (v != 64'd0) ? mask : 64'd0;
        end
        if ((v >> (width - sh)) != 64'd0) begin
            return mask;
        end
        return (v << sh) & mask;
    endfunction

endpackage

// File: rtl/energy_accumulator.sv
// Squares signed samples and sums them over a 2^N block; the block length is
// chosen per mode (calibration or window) and done fires on the last sample.
module energy_accumulator #(
    parameter int DATA_WIDTH = 16,
    parameter int CAL_LOG2   = 10,
    parameter int WIN_LOG2   = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      in_valid,
    input  logic                      cal_mode,
    input  logic [DATA_WIDTH-1:0]     sample_in,
    output logic                      done,
    output logic [2*DATA_WIDTH-1:0]   mean
);
    localparam int EW   = 2 * DATA_WIDTH;
    localparam int NMAX = (CAL_LOG2 > WIN_LOG2) ? CAL_LOG2 : WIN_LOG2;
    localparam int CW   = (NMAX < 1) ? 1 : NMAX;
    localparam int AW   = EW + NMAX;
    localparam logic [CW-1:0] CAL_LAST = CW'((64'd1 << CAL_LOG2) - 64'd1);
    localparam logic [CW-1:0] WIN_LAST = CW'((64'd1 << WIN_LOG2) - 64'd1);

    logic signed [EW-1:0] sample_ext;
    logic [EW-1:0]        energy;
    logic [AW-1:0]        acc_q, acc_d;
    logic [AW-1:0]        sum;
    logic [AW-1:0]        shifted;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 last;

    // Squaring at full 2*DATA_WIDTH keeps the most negative input exact.
    assign sample_ext = EW'($signed(sample_in));
    assign energy     = sample_ext * sample_ext;
    assign sum        = acc_q + AW'(energy);
    assign last       = (cnt_q == (cal_mode ? CAL_LAST : WIN_LAST));
    assign done       = in_valid && last && !clear;
    assign shifted    = cal_mode ? (sum >> CAL_LOG2) : (sum >> WIN_LOG2);
    assign mean       = EW'(shifted);

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clear || done) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (in_valid) begin
            acc_d = sum;
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/noise_gate_calibrator.sv
// Calibrates a mean-square noise floor, then gates windowed energy against it
// with hysteresis and emits holdoff-limited beat strobes.
module noise_gate_calibrator
    import noise_gate_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int CAL_LOG2    = 10,
    parameter int WIN_LOG2    = 6,
    parameter int GATE_SHIFT  = 2,
    parameter int HOLDOFF_WIN = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      recal_req,
    input  logic [DATA_WIDTH-1:0]     sample_in,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    output logic                      calibrating,
    output logic [2*DATA_WIDTH-1:0]   noise_floor,
    output logic [2*DATA_WIDTH-1:0]   win_energy,
    output logic                      win_valid,
    input  logic                      win_ready,
    output logic                      gate_open,
    output logic                      beat_pulse
);
    localparam int EW = 2 * DATA_WIDTH;
    localparam int HW = (HOLDOFF_WIN < 1) ? 1 : $clog2(HOLDOFF_WIN + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_WIN);

    ng_state_e     state_q, state_d;
    logic [EW-1:0] noise_floor_q, noise_floor_d;
    logic [EW-1:0] win_energy_q, win_energy_d;
    logic          win_valid_q, win_valid_d;
    logic          gate_open_q, gate_open_d;
    logic          beat_pulse_q, beat_pulse_d;
    logic [HW-1:0] holdoff_q, holdoff_d;

    logic          accept;
    logic          acc_done;
    logic [EW-1:0] acc_mean;
    logic [EW-1:0] open_thr;
    logic [EW-1:0] close_thr;

    // Both ports use valid/ready: a transfer happens on an edge where both are
    // high, and a producer holds its payload steady while valid waits on ready.
    assign sample_ready = (state_q == ST_CAL) || !win_valid_q;
    assign accept       = sample_valid && sample_ready;

    assign open_thr  = EW'(sat_shl(64'(noise_floor_q), GATE_SHIFT, EW));
    assign close_thr = EW'(sat_shl(64'(noise_floor_q), GATE_SHIFT - 1, EW));

    energy_accumulator #(
        .DATA_WIDTH (DATA_WIDTH),
        .CAL_LOG2   (CAL_LOG2),
        .WIN_LOG2   (WIN_LOG2)
    ) u_acc (
        .clk       (clk),
        .reset     (reset),
        .clear     (recal_req),
        .in_valid  (accept),
        .cal_mode  (state_q == ST_CAL),
        .sample_in (sample_in),
        .done      (acc_done),
        .mean      (acc_mean)
    );

    always_comb begin
        state_d       = state_q;
        noise_floor_d = noise_floor_q;
        win_energy_d  = win_energy_q;
        win_valid_d   = win_valid_q;
        gate_open_d   = gate_open_q;
        beat_pulse_d  = 1'b0;
        holdoff_d     = holdoff_q;
        if (recal_req) begin
            state_d     = ST_CAL;
            win_valid_d = 1'b0;
            gate_open_d = 1'b0;
            holdoff_d   = '0;
        end else if (state_q == ST_CAL) begin
            win_valid_d = 1'b0;
            gate_open_d = 1'b0;
            if (acc_done) begin
                noise_floor_d = acc_mean;
                state_d       = ST_RUN;
            end
        end else begin
            if (win_valid_q && win_ready) begin
                win_valid_d = 1'b0;
            end
            if (acc_done) begin
                win_energy_d = acc_mean;
                win_valid_d  = 1'b1;
                if (acc_mean > open_thr) begin
                    gate_open_d = 1'b1;
                end else if (acc_mean < close_thr) begin
                    gate_open_d = 1'b0;
                end
                // A rising gate only counts as a beat once the holdoff has drained.
                if (gate_open_d && !gate_open_q && (holdoff_q == '0)) begin
                    beat_pulse_d = 1'b1;
                    holdoff_d    = HOLD_LOAD;
                end else if (holdoff_q != '0) begin
                    holdoff_d = holdoff_q - HW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_CAL;
            noise_floor_q <= '0;
            win_energy_q  <= '0;
            win_valid_q   <= 1'b0;
            gate_open_q   <= 1'b0;
            beat_pulse_q  <= 1'b0;
            holdoff_q     <= '0;
        end else begin
            state_q       <= state_d;
            noise_floor_q <= noise_floor_d;
            win_energy_q  <= win_energy_d;
            win_valid_q   <= win_valid_d;
            gate_open_q   <= gate_open_d;
            beat_pulse_q  <= beat_pulse_d;
            holdoff_q     <= holdoff_d;
        end
    end

    assign calibrating = (state_q == ST_CAL);
    assign noise_floor = noise_floor_q;
    assign win_energy  = win_energy_q;
    assign win_valid   = win_valid_q;
    assign gate_open   = gate_open_q;
    assign beat_pulse  = beat_pulse_q;

endmodule

// File: tb/tb_noise_gate_calibrator.sv
// Self-checking bench for noise_gate_calibrator: directed tables and sequences
// plus randomized traffic compared cycle by cycle with a block-level model.
module tb_noise_gate_calibrator;
    localparam int DW          = 16;
    localparam int CAL_LOG2    = 4;
    localparam int WIN_LOG2    = 2;
    localparam int GATE_SHIFT  = 2;
    localparam int HOLDOFF_WIN = 2;
    localparam int CAL_N       = 1 << CAL_LOG2;
    localparam int WIN_N       = 1 << WIN_LOG2;
    localparam longint SAT_MAX = 64'h0000_0000_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          reset;
    logic          recal_req;
    logic [DW-1:0] sample_in;
    logic          sample_valid;
    logic          sample_ready;
    logic          calibrating;
    logic [31:0]   noise_floor;
    logic [31:0]   win_energy;
    logic          win_valid;
    logic          win_ready;
    logic          gate_open;
    logic          beat_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: per-block sample list and the spec-level outputs.
    bit          m_cal, m_wv, m_gate, m_beat;
    longint      m_nf, m_we;
    int          m_hold;
    int          blk_q[$];
    logic [31:0] exp_q[$];

    typedef struct {
        int          level;
        logic [31:0] exp_energy;
        logic        exp_gate;
        logic        exp_beat;
    } win_vec_t;
    win_vec_t vecs[7];

    always #5 clk = ~clk;

    noise_gate_calibrator #(
        .DATA_WIDTH  (DW),
        .CAL_LOG2    (CAL_LOG2),
        .WIN_LOG2    (WIN_LOG2),
        .GATE_SHIFT  (GATE_SHIFT),
        .HOLDOFF_WIN (HOLDOFF_WIN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .recal_req    (recal_req),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .calibrating  (calibrating),
        .noise_floor  (noise_floor),
        .win_energy   (win_energy),
        .win_valid    (win_valid),
        .win_ready    (win_ready),
        .gate_open    (gate_open),
        .beat_pulse   (beat_pulse)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cal  = 1'b1;
        m_wv   = 1'b0;
        m_gate = 1'b0;
        m_beat = 1'b0;
        m_nf   = 0;
        m_we   = 0;
        m_hold = 0;
        blk_q.delete();
        exp_q.delete();
    endtask

    // Apply the block's rules to the inputs present at one clock edge.
    task automatic model_edge();
        bit     acc;
        bit     was_gate;
        longint sum, mean, open_thr, close_thr;
        m_beat = 1'b0;
        if (recal_req) begin
            m_cal  = 1'b1;
            m_wv   = 1'b0;
            m_gate = 1'b0;
            m_hold = 0;
            blk_q.delete();
            exp_q.delete();
            return;
        end
        acc = sample_valid && (m_cal || !m_wv);
        if (!m_cal && m_wv && win_ready) m_wv = 1'b0;
        if (!acc) return;
        blk_q.push_back(int'($signed(sample_in)));
        if (blk_q.size() < (m_cal ? CAL_N : WIN_N)) return;
        sum = 0;
        foreach (blk_q[i]) sum += longint'(blk_q[i]) * longint'(blk_q[i]);
        mean = sum / blk_q.size();
        blk_q.delete();
        if (m_cal) begin
            m_nf  = mean;
            m_cal = 1'b0;
            return;
        end
        m_we = mean;
        m_wv = 1'b1;
        exp_q.push_back(32'(mean));
        open_thr  = m_nf * (longint'(1) << GATE_SHIFT);
        if (open_thr > SAT_MAX) open_thr = SAT_MAX;
        close_thr = m_nf * (longint'(1) << (GATE_SHIFT - 1));
        was_gate  = m_gate;
        if (mean > open_thr) m_gate = 1'b1;
        else if (mean < close_thr) m_gate = 1'b0;
        if (m_gate && !was_gate && m_hold == 0) begin
            m_beat = 1'b1;
            m_hold = HOLDOFF_WIN;
        end else if (m_hold > 0) begin
            m_hold--;
        end
    endtask

    task automatic check_all();
        check("sample_ready", sample_ready, m_cal || !m_wv);
        check("calibrating",  calibrating,  m_cal);
        check("noise_floor",  noise_floor,  m_nf);
        check("win_energy",   win_energy,   m_we);
        check("win_valid",    win_valid,    m_wv);
        check("gate_open",    gate_open,    m_gate);
        check("beat_pulse",   beat_pulse,   m_beat);
    endtask

    // One clock: scoreboard any window handshake, step the model, compare.
    task automatic cycle();
        bit          hs;
        logic [31:0] got;
        hs  = win_valid && win_ready && !reset;
        got = win_energy;
        @(posedge clk);
        if (hs) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard: unexpected window %0d consumed", got);
            end else begin
                check("scoreboard", got, exp_q.pop_front());
            end
        end
        model_edge();
        #1;
        check_all();
    endtask

    task automatic send(input int v);
        int n;
        bit took;
        n = 0;
        sample_in    = DW'(v);
        sample_valid = 1'b1;
        do begin
            took = m_cal || !m_wv;
            cycle();
            n++;
        end while (!took && n < 20);
        sample_valid = 1'b0;
        if (!took) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: sample %0d not accepted within 20 cycles", v);
        end
    endtask

    initial begin
        vecs[0] = '{400, 32'd160000, 1'b1, 1'b1};
        vecs[1] = '{0,   32'd0,      1'b0, 1'b0};
        vecs[2] = '{400, 32'd160000, 1'b1, 1'b0};
        vecs[3] = '{0,   32'd0,      1'b0, 1'b0};
        vecs[4] = '{400, 32'd160000, 1'b1, 1'b1};
        vecs[5] = '{150, 32'd22500,  1'b1, 1'b0};
        vecs[6] = '{100, 32'd10000,  1'b0, 1'b0};

        reset        = 1'b1;
        recal_req    = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        win_ready    = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
        cycle();
        check("ready_after_reset", sample_ready, 1);

        // Calibration with alternating +/-100.
        for (int i = 0; i < CAL_N; i++) begin
            send((i % 2 == 0) ? 100 : -100);
            if (i < CAL_N - 1) check("cal_busy", calibrating, 1);
        end
        check("cal_floor", noise_floor, 10000);
        check("cal_done", calibrating, 0);

        // Window table: gate hysteresis and beat holdoff.
        for (int k = 0; k < 7; k++) begin
            for (int j = 0; j < WIN_N; j++) send(vecs[k].level);
            check($sformatf("tbl%0d_energy", k), win_energy, vecs[k].exp_energy);
            check($sformatf("tbl%0d_valid", k),  win_valid,  1);
            check($sformatf("tbl%0d_gate", k),   gate_open,  vecs[k].exp_gate);
            check($sformatf("tbl%0d_beat", k),   beat_pulse, vecs[k].exp_beat);
            cycle();
            check($sformatf("tbl%0d_beat_end", k), beat_pulse, 0);
        end

        // Backpressure on the window output.
        win_ready = 1'b0;
        for (int j = 0; j < WIN_N; j++) send(400);
        check("bp_valid_set", win_valid, 1);
        sample_valid = 1'b1;
        sample_in    = DW'(1234);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_ready", sample_ready, 0);
            check("bp_energy", win_energy, 160000);
            check("bp_valid", win_valid, 1);
        end
        sample_valid = 1'b0;
        win_ready    = 1'b1;
        cycle();
        check("bp_release_valid", win_valid, 0);
        check("bp_release_ready", sample_ready, 1);

        // Recalibration mid-window, then full-scale negative samples.
        send(400);
        send(400);
        recal_req = 1'b1;
        cycle();
        recal_req = 1'b0;
        check("recal_cal", calibrating, 1);
        check("recal_valid", win_valid, 0);
        check("recal_gate", gate_open, 0);
        check("recal_floor_kept", noise_floor, 10000);
        for (int i = 0; i < CAL_N; i++) begin
            send(-32768);
            if (i < CAL_N - 1) check("recal_floor_hold", noise_floor, 10000);
        end
        check("recal_floor_new", noise_floor, 1073741824);
        check("recal_done", calibrating, 0);
        for (int j = 0; j < WIN_N; j++) send(-32768);
        check("max_neg_energy", win_energy, 1073741824);
        check("sat_thr_gate", gate_open, 0);
        cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            sample_valid = ($urandom_range(0, 9) < 7);
            win_ready    = ($urandom_range(0, 9) < 6);
            recal_req    = ($urandom_range(0, 299) == 0);
            case ($urandom_range(0, 3))
                0:       sample_in = DW'(int'($urandom_range(0, 100)) - 50);
                1:       sample_in = DW'(int'($urandom_range(0, 1000)) - 500);
                2:       sample_in = DW'($urandom);
                default: sample_in = DW'(-32768);
            endcase
            cycle();
        end
        recal_req    = 1'b0;
        sample_valid = 1'b0;

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_cal", calibrating, 1);
        check("async_rst_valid", win_valid, 0);
        check("async_rst_floor", noise_floor, 0);
        check("async_rst_energy", win_energy, 0);
        check("async_rst_gate", gate_open, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
